// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory interface stage.
package lc3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  localparam logic [15:0] ADDR_KBSR    = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR    = 16'hFE02;
  localparam logic [15:0] ADDR_DSR     = 16'hFE04;
  localparam logic [15:0] ADDR_DDR     = 16'hFE06;
  localparam logic [15:0] MEM_ERR_DATA = 16'hDEAD;

  function automatic logic is_mmio_addr(input logic [15:0] addr);
    return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
           (addr == ADDR_DSR)  || (addr == ADDR_DDR);
  endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 keyboard/display device registers: keyboard buffer, display output, read decode.
// acc is high for the single ACCESS cycle of a device-register access.
module lc3_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        acc,
  input  logic        wr,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic        dsr_ready,
  output logic [15:0] rdata,
  output logic [7:0]  ddr_data,
  output logic        ddr_valid
);

  logic       kbd_full_q, kbd_full_d;
  logic [7:0] kbd_char_q, kbd_char_d;
  logic [7:0] ddr_data_q, ddr_data_d;
  logic       ddr_valid_q, ddr_valid_d;
  logic       rd_kbdr, wr_ddr;

  always_comb begin
    rd_kbdr     = acc && !wr && (addr == ADDR_KBDR);
    wr_ddr      = acc && wr && (addr == ADDR_DDR);
    kbd_full_d  = kbd_full_q;
    kbd_char_d  = kbd_char_q;
    ddr_data_d  = ddr_data_q;
    ddr_valid_d = wr_ddr;
    // A KBDR read in the same cycle as a new key drops the new key.
    if (rd_kbdr) begin
      kbd_full_d = 1'b0;
    end else if (kbd_valid && !kbd_full_q) begin
      kbd_full_d = 1'b1;
      kbd_char_d = kbd_data;
    end
    if (wr_ddr) begin
      ddr_data_d = wdata;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_KBSR: rdata = {kbd_full_q, 15'b0};
      ADDR_KBDR: rdata = {8'b0, kbd_char_q};
      ADDR_DSR:  rdata = {dsr_ready, 15'b0};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_full_q  <= 1'b0;
      kbd_char_q  <= '0;
      ddr_data_q  <= '0;
      ddr_valid_q <= 1'b0;
    end else begin
      kbd_full_q  <= kbd_full_d;
      kbd_char_q  <= kbd_char_d;
      ddr_data_q  <= ddr_data_d;
      ddr_valid_q <= ddr_valid_d;
    end
  end

  assign ddr_data  = ddr_data_q;
  assign ddr_valid = ddr_valid_q;

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: MAR/MDR registers and the request/ack access sequencer.
// Define LC3_MMIO_EN to decode the keyboard/display registers internally.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mem_req,
  input  logic        r_w,
  output logic [15:0] mar_out,
  output logic [15:0] mdr_out,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic        dsr_ready,
  output logic [7:0]  ddr_data,
  output logic        ddr_valid
);

  localparam int unsigned     CntW   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_LIMIT);

  mem_state_t      state_q, state_d;
  logic [15:0]     mar_q, mar_d;
  logic [15:0]     mdr_q, mdr_d;
  logic            wr_q, wr_d;
  logic            mmio_q, mmio_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic            en_q, en_d;
  logic            we_q, we_d;
  logic            mmio_hit;
  logic [15:0]     mmio_rdata;

`ifdef LC3_MMIO_EN
  logic mmio_acc;

  // Decode the address the access will actually use, including a same-cycle MAR load.
  assign mmio_hit = is_mmio_addr(ld_mar ? bus_in : mar_q);
  assign mmio_acc = (state_q == ACCESS) && mmio_q;

  lc3_mmio_regs u_mmio_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (mar_q),
    .wdata     (mdr_q[7:0]),
    .acc       (mmio_acc),
    .wr        (wr_q),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .dsr_ready (dsr_ready),
    .rdata     (mmio_rdata),
    .ddr_data  (ddr_data),
    .ddr_valid (ddr_valid)
  );
`else
  logic unused_mmio;

  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign ddr_data    = '0;
  assign ddr_valid   = 1'b0;
  assign unused_mmio = ^{kbd_data, kbd_valid, dsr_ready};
`endif

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    wr_d    = wr_q;
    mmio_d  = mmio_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ready_d = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = bus_in;
        if (ld_mdr) mdr_d = bus_in;
        if (mem_req) begin
          state_d = ACCESS;
          wr_d    = r_w;
          mmio_d  = mmio_hit;
          cnt_d   = '0;
          en_d    = !mmio_hit;
          we_d    = !mmio_hit && r_w;
        end
      end
      ACCESS: begin
        en_d = en_q;
        we_d = we_q;
        if (mmio_q) begin
          state_d = DONE;
          ready_d = 1'b1;
          en_d    = 1'b0;
          we_d    = 1'b0;
          if (!wr_q) mdr_d = mmio_rdata;
        end else if (mem_ack) begin
          // Ack takes priority over a timeout in the same cycle.
          state_d = DONE;
          ready_d = 1'b1;
          en_d    = 1'b0;
          we_d    = 1'b0;
          if (!wr_q) mdr_d = mem_rdata;
        end else if (cnt_q == CntMax) begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
          en_d    = 1'b0;
          we_d    = 1'b0;
          if (!wr_q) mdr_d = MEM_ERR_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      wr_q    <= 1'b0;
      mmio_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      wr_q    <= wr_d;
      mmio_q  <= mmio_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      en_q    <= en_d;
      we_q    <= we_d;
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Self-checking bench for lc3_mem_if: directed scenarios plus randomized accesses
// against a transaction-level model (latency, MDR result, sticky error, memory contents).
module tb_lc3_mem_if;

  localparam int WL = 4;

  logic        clk, rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mem_req, r_w;
  logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, mem_err, mem_en, mem_we, mem_ack;
  logic [7:0]  kbd_data, ddr_data;
  logic        kbd_valid, dsr_ready, ddr_valid;

  int checks = 0;
  int errors = 0;
  bit err_model = 1'b0;

  logic [15:0] ext_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  lc3_mem_if #(.WAIT_LIMIT(WL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .mem_req   (mem_req),
    .r_w       (r_w),
    .mar_out   (mar_out),
    .mdr_out   (mdr_out),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .dsr_ready (dsr_ready),
    .ddr_data  (ddr_data),
    .ddr_valid (ddr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] mem_default(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Loads MAR/MDR, issues one request and plays the external memory, acking in
  // cycle ack_at (cycle 1 = first cycle after the request edge).
  task automatic run_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input bit same_load, input int ack_at,
                            output int ready_cyc, output int en_cyc, output int we_cyc,
                            output int bad_bus, output int ready_cnt, output int ddr_cyc,
                            output bit ddr_with_ready);
    ready_cyc = -1; en_cyc = 0; we_cyc = 0; bad_bus = 0; ready_cnt = 0; ddr_cyc = 0;
    ddr_with_ready = 1'b0;
    @(negedge clk);
    ld_mar = 1'b1; ld_mdr = 1'b0;
    bus_in = (same_load && !wr) ? (addr ^ 16'h0100) : addr;
    @(negedge clk);
    ld_mar = 1'b0; ld_mdr = 1'b1;
    bus_in = (same_load && wr) ? ~wdata : wdata;
    @(negedge clk);
    ld_mar = same_load && !wr; ld_mdr = same_load && wr;
    bus_in = wr ? wdata : addr;
    mem_req = 1'b1; r_w = wr;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mem_req = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; r_w = 1'b0; bus_in = 16'($urandom);
      end
      if (mem_en) begin
        en_cyc++;
        if (mem_we) we_cyc++;
        if (mem_addr !== addr || (wr && mem_wdata !== wdata)) bad_bus++;
      end
      if (ddr_valid) begin
        ddr_cyc++;
        if (mem_ready) ddr_with_ready = 1'b1;
      end
      if (mem_ready) begin
        ready_cnt++;
        if (ready_cyc < 0) ready_cyc = c;
      end
      if (c == ack_at) begin
        mem_ack = 1'b1;
        if (mem_en && mem_we) ext_mem[mem_addr] = mem_wdata;
        mem_rdata = ext_mem.exists(mem_addr) ? ext_mem[mem_addr] : mem_default(mem_addr);
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
      end
      if (ready_cyc >= 0 && c > ready_cyc) break;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_in = '0; ld_mar = 0; ld_mdr = 0; mem_req = 0; r_w = 0; mem_rdata = '0; mem_ack = 0;
    kbd_data = '0; kbd_valid = 0; dsr_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mar_out !== 16'h0) begin errors++; $display("FAIL rst_mar: got %h want 0000", mar_out); end
    checks++; if (mdr_out !== 16'h0) begin errors++; $display("FAIL rst_mdr: got %h want 0000", mdr_out); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", mem_ready); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", mem_err); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
    checks++; if (ddr_data !== 8'h0) begin errors++; $display("FAIL rst_ddr_data: got %h want 00", ddr_data); end
    checks++; if (ddr_valid !== 1'b0) begin errors++; $display("FAIL rst_ddr_valid: got %b want 0", ddr_valid); end
  endtask

  task automatic test_read();
    int rc, en, we, bad, rn, dc;
    bit dr;
    ext_mem[16'h3000] = 16'h1234;
    ref_mem[16'h3000] = 16'h1234;
    run_access(1'b0, 16'h3000, 16'h0000, 1'b0, 1, rc, en, we, bad, rn, dc, dr);
    checks++; if (rc !== 2) begin errors++; $display("FAIL rd_ready_cyc: got %0d want 2", rc); end
    checks++; if (en !== 1) begin errors++; $display("FAIL rd_en_cycles: got %0d want 1", en); end
    checks++; if (we !== 0) begin errors++; $display("FAIL rd_we_cycles: got %0d want 0", we); end
    checks++; if (rn !== 1) begin errors++; $display("FAIL rd_ready_pulses: got %0d want 1", rn); end
    checks++; if (mdr_out !== 16'h1234) begin errors++; $display("FAIL rd_mdr: got %h want 1234", mdr_out); end
    checks++; if (mar_out !== 16'h3000) begin errors++; $display("FAIL rd_mar: got %h want 3000", mar_out); end
  endtask

  task automatic test_write_waits();
    int rc, en, we, bad, rn, dc;
    bit dr;
    run_access(1'b1, 16'h4000, 16'hBEEF, 1'b0, 4, rc, en, we, bad, rn, dc, dr);
    checks++; if (rc !== 5) begin errors++; $display("FAIL wr_ready_cyc: got %0d want 5", rc); end
    checks++; if (en !== 4 || we !== 4) begin
      errors++; $display("FAIL wr_en_we_cycles: got en=%0d we=%0d want 4/4", en, we);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr_bus: got %0d bad cycles want 0", bad); end
    checks++; if (ext_mem[16'h4000] !== 16'hBEEF) begin
      errors++; $display("FAIL wr_mem: got %h want beef", ext_mem[16'h4000]);
    end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", mem_err); end
  endtask

  task automatic test_ld_during_access();
    int bad = 0, rc = -1, post_en = 0;
    @(negedge clk); ld_mar = 1; bus_in = 16'h5000;
    @(negedge clk); ld_mar = 0; ld_mdr = 1; bus_in = 16'h1111;
    @(negedge clk); ld_mdr = 0; mem_req = 1; r_w = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mar_out !== 16'h5000 || mdr_out !== 16'h1111) bad++;
      if (mem_ready && rc < 0) rc = c;
      ld_mar = 1; ld_mdr = 1; mem_req = 1; bus_in = 16'hFFFF;
      mem_ack = (c == 3);
      if (rc >= 0 && c > rc) break;
    end
    ld_mar = 0; ld_mdr = 0; mem_req = 0; r_w = 0; mem_ack = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_en) post_en++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ld_ignored: got %0d changed cycles want 0", bad); end
    checks++; if (rc !== 4) begin errors++; $display("FAIL ld_ready_cyc: got %0d want 4", rc); end
    checks++; if (post_en !== 0) begin errors++; $display("FAIL req_ignored: got %0d en cycles want 0", post_en); end
  endtask

  task automatic test_timeout();
    int rc, en, we, bad, rn, dc;
    bit dr;
    run_access(1'b0, 16'h3100, 16'h0000, 1'b0, 99, rc, en, we, bad, rn, dc, dr);
    err_model = 1'b1;
    checks++; if (rc !== WL + 2) begin errors++; $display("FAIL to_ready_cyc: got %0d want %0d", rc, WL + 2); end
    checks++; if (en !== WL + 1) begin errors++; $display("FAIL to_en_cycles: got %0d want %0d", en, WL + 1); end
    checks++; if (mdr_out !== 16'hDEAD) begin errors++; $display("FAIL to_mdr: got %h want dead", mdr_out); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", mem_err); end
    run_access(1'b0, 16'h3000, 16'h0000, 1'b0, 1, rc, en, we, bad, rn, dc, dr);
    checks++; if (mem_err !== 1'b1 || mdr_out !== 16'h1234) begin
      errors++; $display("FAIL to_sticky: got err=%b mdr=%h want 1/1234", mem_err, mdr_out);
    end
  endtask

  task automatic test_reset_mid_access();
    int seen_ready = 0, seen_en = 0;
    @(negedge clk); ld_mar = 1; bus_in = 16'h3200;
    @(negedge clk); ld_mar = 0; mem_req = 1; r_w = 0;
    @(negedge clk); mem_req = 0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rma_en_before: got %b want 1", mem_en); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rma_en_async: got %b want 0", mem_en); end
    repeat (2) begin
      @(negedge clk);
      if (mem_ready) seen_ready++;
    end
    rst_n = 1'b1;
    err_model = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ready) seen_ready++;
      if (mem_en) seen_en++;
    end
    checks++; if (seen_ready !== 0 || seen_en !== 0) begin
      errors++; $display("FAIL rma_quiet: got ready=%0d en=%0d want 0/0", seen_ready, seen_en);
    end
    checks++; if (mem_err !== 1'b0 || mar_out !== 16'h0) begin
      errors++; $display("FAIL rma_state: got err=%b mar=%h want 0/0000", mem_err, mar_out);
    end
  endtask

  task automatic test_random();
    int rc, en, we, bad, rn, dc;
    bit dr, ok, same;
    logic wr;
    int ack_at, exp_rc;
    logic [15:0] addr, wdata, exp_mdr;
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom);
      same = 1'($urandom);
      addr = 16'h3000 + 16'($urandom_range(0, 15));
      wdata = 16'($urandom);
      ack_at = $urandom_range(1, WL + 3);
      ok = (ack_at <= WL + 1);
      exp_rc = ok ? ack_at + 1 : WL + 2;
      if (wr) exp_mdr = wdata;
      else if (!ok) exp_mdr = 16'hDEAD;
      else exp_mdr = ref_mem.exists(addr) ? ref_mem[addr] : mem_default(addr);
      if (ok && wr) ref_mem[addr] = wdata;
      if (!ok) err_model = 1'b1;
      run_access(wr, addr, wdata, same, ack_at, rc, en, we, bad, rn, dc, dr);
      checks++; if (rc !== exp_rc || rn !== 1) begin
        errors++; $display("FAIL rnd%0d_ready: got cyc=%0d pulses=%0d want %0d/1", i, rc, rn, exp_rc);
      end
      checks++; if (en !== exp_rc - 1 || we !== (wr ? exp_rc - 1 : 0) || bad !== 0) begin
        errors++;
        $display("FAIL rnd%0d_bus: got en=%0d we=%0d bad=%0d want %0d/%0d/0", i, en, we, bad,
                 exp_rc - 1, wr ? exp_rc - 1 : 0);
      end
      checks++; if (mdr_out !== exp_mdr || mar_out !== addr) begin
        errors++;
        $display("FAIL rnd%0d_regs: got mdr=%h mar=%h want %h/%h", i, mdr_out, mar_out, exp_mdr, addr);
      end
      checks++; if (mem_err !== err_model) begin
        errors++; $display("FAIL rnd%0d_err: got %b want %b", i, mem_err, err_model);
      end
    end
  endtask

  task automatic test_mmio();
    int rc, en, we, bad, rn, dc;
    bit dr;
`ifdef LC3_MMIO_EN
    logic [15:0] addrs [5] = '{16'hFE00, 16'hFE02, 16'hFE00, 16'hFE04, 16'hFE04};
    logic [15:0] exps  [5] = '{16'h8000, 16'h0041, 16'h0000, 16'h8000, 16'h0000};
    @(negedge clk); kbd_data = 8'h41; kbd_valid = 1;
    @(negedge clk); kbd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        @(negedge clk); kbd_data = 8'h42; kbd_valid = 1;
        @(negedge clk); kbd_valid = 0;
      end
      dsr_ready = (i == 3);
      run_access(1'b0, addrs[i], 16'h0000, 1'b0, 1, rc, en, we, bad, rn, dc, dr);
      checks++; if (mdr_out !== exps[i] || rc !== 2 || en !== 0) begin
        errors++;
        $display("FAIL mmio_rd%0d: got mdr=%h cyc=%0d en=%0d want %h/2/0", i, mdr_out, rc, en, exps[i]);
      end
    end
    run_access(1'b1, 16'hFE06, 16'h0058, 1'b0, 1, rc, en, we, bad, rn, dc, dr);
    checks++; if (ddr_data !== 8'h58 || dc !== 1 || !dr) begin
      errors++; $display("FAIL mmio_ddr: got data=%h valid_cyc=%0d with_ready=%b want 58/1/1", ddr_data, dc, dr);
    end
    checks++; if (en !== 0 || rc !== 2) begin
      errors++; $display("FAIL mmio_ddr_ext: got en=%0d cyc=%0d want 0/2", en, rc);
    end
`else
    run_access(1'b1, 16'hFE06, 16'h0058, 1'b0, 1, rc, en, we, bad, rn, dc, dr);
    checks++; if (en !== 1 || we !== 1 || rc !== 2 || bad !== 0) begin
      errors++; $display("FAIL ext_ddr_write: got en=%0d we=%0d cyc=%0d bad=%0d want 1/1/2/0", en, we, rc, bad);
    end
    checks++; if (dc !== 0 || ddr_data !== 8'h00) begin
      errors++; $display("FAIL ext_no_ddr: got valid_cyc=%0d data=%h want 0/00", dc, ddr_data);
    end
    run_access(1'b0, 16'hFE06, 16'h0000, 1'b0, 2, rc, en, we, bad, rn, dc, dr);
    checks++; if (mdr_out !== 16'h0058 || en !== 2 || rc !== 3) begin
      errors++; $display("FAIL ext_fe06_read: got mdr=%h en=%0d cyc=%0d want 0058/2/3", mdr_out, en, rc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_waits();
    test_ld_during_access();
    test_timeout();
    test_reset_mid_access();
    test_random();
    test_mmio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
